// File: rtl/deco_bcd_bin_seq.sv
// Sequential packed-BCD to binary converter for RTC read-back data.
// One byte per request, five-cycle shift-and-add datapath, 12-h AM/PM extraction.
module deco_bcd_bin_seq #(
  parameter int MAX_VAL = 99
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       start,
  input  logic [7:0] rd_bcd,
  input  logic       sel_hora,
  input  logic       sf_24_12,
  output logic       busy,
  output logic       done,
  output logic [6:0] rd_bin,
  output logic       am_pm,
  output logic       err_bcd,
  output logic       err_rng
);

  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    CHECK = 3'd1,
    MUL8  = 3'd2,
    ADD2  = 3'd3,
    ADDU  = 3'd4,
    FIN   = 3'd5
  } state_t;

  localparam logic [7:0] MAX_W = 8'(MAX_VAL);

  state_t     state, state_nxt;
  logic [7:0] opnd;
  logic [6:0] acc;
  logic       ampm_r;
  logic       err_r;

  logic [3:0] tens, units;
  assign tens  = opnd[7:4];
  assign units = opnd[3:0];

  // NOTE: reset is synchronous, so it lives inside the clocked branch and
  // every state register, including the operand and accumulator, is cleared.
  always_ff @(posedge clk) begin
    if (reset) state <= IDLE;
    else       state <= state_nxt;
  end

  // NOTE: state_nxt gets a default before the case so no path leaves it
  // unassigned; otherwise synthesis infers a latch.
  always_comb begin
    state_nxt = state;
    unique case (state)
      IDLE:    if (start) state_nxt = CHECK;
      CHECK:   state_nxt = MUL8;
      MUL8:    state_nxt = ADD2;
      ADD2:    state_nxt = ADDU;
      ADDU:    state_nxt = FIN;
      FIN:     state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  // NOTE: all registers below use non-blocking assignments so every branch
  // sees the values from before this edge, independent of statement order.
  always_ff @(posedge clk) begin
    if (reset) begin
      opnd    <= '0;
      acc     <= '0;
      ampm_r  <= 1'b0;
      err_r   <= 1'b0;
      busy    <= 1'b0;
      done    <= 1'b0;
      rd_bin  <= '0;
      am_pm   <= 1'b0;
      err_bcd <= 1'b0;
      err_rng <= 1'b0;
    end else begin
      done <= 1'b0;
      unique case (state)
        IDLE: begin
          if (start) begin
            busy <= 1'b1;
            // In 12-h hour reads bit 7 is the PM flag, not part of the tens digit.
            if (sel_hora && sf_24_12) begin
              ampm_r <= rd_bcd[7];
              opnd   <= {1'b0, rd_bcd[6:0]};
            end else begin
              ampm_r <= 1'b0;
              opnd   <= rd_bcd;
            end
          end
        end
        CHECK: err_r <= (tens > 4'd9) || (units > 4'd9);
        MUL8:  acc   <= {tens, 3'b000};
        ADD2:  acc   <= acc + {2'b00, tens, 1'b0};
        ADDU:  acc   <= acc + {3'b000, units};
        FIN: begin
          done    <= 1'b1;
          busy    <= 1'b0;
          am_pm   <= ampm_r;
          err_bcd <= err_r;
          if (err_r) begin
            rd_bin  <= '0;
            err_rng <= 1'b0;
          end else begin
            rd_bin  <= acc;
            err_rng <= ({1'b0, acc} > MAX_W);
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_deco_bcd_bin_seq.sv
// Self-checking bench for deco_bcd_bin_seq: directed cases plus random bytes
// against an arithmetic reference model, on a default and a MAX_VAL=59 instance.
module tb_deco_bcd_bin_seq;

  typedef struct packed {
    logic [6:0] bin;
    logic       ampm;
    logic       eb;
    logic       er;
  } res_t;

  logic       clk = 1'b0;
  logic       reset, start, sel_hora, sf_24_12;
  logic [7:0] rd_bcd;

  logic       busy_d, done_d, am_pm_d, err_bcd_d, err_rng_d;
  logic [6:0] rd_bin_d;
  logic       busy_m, done_m, am_pm_m, err_bcd_m, err_rng_m;
  logic [6:0] rd_bin_m;

  int errors = 0;
  int checks = 0;

  always #5 clk = ~clk;

  deco_bcd_bin_seq dut_d (
    .clk(clk), .reset(reset), .start(start), .rd_bcd(rd_bcd),
    .sel_hora(sel_hora), .sf_24_12(sf_24_12),
    .busy(busy_d), .done(done_d), .rd_bin(rd_bin_d), .am_pm(am_pm_d),
    .err_bcd(err_bcd_d), .err_rng(err_rng_d)
  );

  deco_bcd_bin_seq #(.MAX_VAL(59)) dut_m (
    .clk(clk), .reset(reset), .start(start), .rd_bcd(rd_bcd),
    .sel_hora(sel_hora), .sf_24_12(sf_24_12),
    .busy(busy_m), .done(done_m), .rd_bin(rd_bin_m), .am_pm(am_pm_m),
    .err_bcd(err_bcd_m), .err_rng(err_rng_m)
  );

  // Reference: decimal value of the two digits, flags from the digit/range rules.
  function automatic res_t model(input logic [7:0] b, input logic h, input logic s,
                                 input int maxv);
    res_t r;
    int   t, u, val;
    r.ampm = 1'b0;
    if (h && s) begin
      r.ampm = b[7];
      b[7]   = 1'b0;
    end
    t = int'(b[7:4]);
    u = int'(b[3:0]);
    val  = t * 10 + u;
    r.eb = (t > 9) || (u > 9);
    r.bin = r.eb ? 7'd0 : 7'(val);
    r.er  = !r.eb && (val > maxv);
    return r;
  endfunction

  task automatic check(input string tag, input logic [7:0] obs, input logic [7:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  task automatic check_ctl(input string tag, input logic busy_e, input logic done_e);
    check({tag, " busy_d"}, {7'd0, busy_d}, {7'd0, busy_e});
    check({tag, " done_d"}, {7'd0, done_d}, {7'd0, done_e});
    check({tag, " busy_m"}, {7'd0, busy_m}, {7'd0, busy_e});
    check({tag, " done_m"}, {7'd0, done_m}, {7'd0, done_e});
  endtask

  task automatic check_res(input string tag, input res_t ed, input res_t em);
    check({tag, " rd_bin_d"},  {1'b0, rd_bin_d},  {1'b0, ed.bin});
    check({tag, " am_pm_d"},   {7'd0, am_pm_d},   {7'd0, ed.ampm});
    check({tag, " err_bcd_d"}, {7'd0, err_bcd_d}, {7'd0, ed.eb});
    check({tag, " err_rng_d"}, {7'd0, err_rng_d}, {7'd0, ed.er});
    check({tag, " rd_bin_m"},  {1'b0, rd_bin_m},  {1'b0, em.bin});
    check({tag, " am_pm_m"},   {7'd0, am_pm_m},   {7'd0, em.ampm});
    check({tag, " err_bcd_m"}, {7'd0, err_bcd_m}, {7'd0, em.eb});
    check({tag, " err_rng_m"}, {7'd0, err_rng_m}, {7'd0, em.er});
  endtask

  // Called at a negedge with the FSM idle; optionally fires start at k+2 and k+4.
  task automatic convert(input string tag, input logic [7:0] b, input logic h,
                         input logic s, input bit extra);
    res_t ed, em;
    ed = model(b, h, s, 99);
    em = model(b, h, s, 59);
    start = 1'b1; rd_bcd = b; sel_hora = h; sf_24_12 = s;
    @(negedge clk);
    rd_bcd = 8'($urandom); sel_hora = 1'($urandom); sf_24_12 = 1'($urandom);
    check_ctl({tag, " k"}, 1'b1, 1'b0);
    for (int i = 1; i <= 5; i++) begin
      start = extra && (i == 2 || i == 4);
      @(negedge clk);
      if (i < 5) check_ctl({tag, " mid"}, 1'b1, 1'b0);
    end
    check_ctl({tag, " fin"}, 1'b0, 1'b1);
    check_res({tag, " res"}, ed, em);
    start = 1'b0;
    @(negedge clk);
    check_ctl({tag, " after"}, 1'b0, 1'b0);
    check_res({tag, " hold"}, ed, em);
  endtask

  initial begin
    res_t ed, em;
    logic [7:0] b;

    reset = 1'b1; start = 1'b0; rd_bcd = 8'h00; sel_hora = 1'b0; sf_24_12 = 1'b0;
    repeat (2) @(negedge clk);
    ed = '0;
    check_ctl("reset", 1'b0, 1'b0);
    check_res("reset", ed, ed);
    reset = 1'b0;
    @(negedge clk);

    convert("h59",    8'h59, 1'b0, 1'b0, 1'b0);
    convert("h91_12", 8'h91, 1'b1, 1'b1, 1'b0);
    convert("h91_24", 8'h91, 1'b1, 1'b0, 1'b0);
    convert("h3C",    8'h3C, 1'b0, 1'b0, 1'b0);
    convert("hA0",    8'hA0, 1'b0, 1'b0, 1'b0);
    convert("h75",    8'h75, 1'b0, 1'b0, 1'b0);
    convert("h00",    8'h00, 1'b0, 1'b0, 1'b0);
    convert("h60",    8'h60, 1'b0, 1'b0, 1'b0);
    convert("h99",    8'h99, 1'b1, 1'b1, 1'b0);
    convert("ignore", 8'h12, 1'b1, 1'b1, 1'b1);

    // start held high: a new conversion begins the cycle done is high.
    ed = model(8'h88, 1'b1, 1'b1, 99);
    em = model(8'h88, 1'b1, 1'b1, 59);
    start = 1'b1; rd_bcd = 8'h88; sel_hora = 1'b1; sf_24_12 = 1'b1;
    for (int c = 0; c <= 17; c++) begin
      @(negedge clk);
      check_ctl("held", (c % 6) != 5, (c % 6) == 5);
      if ((c % 6) == 5) check_res("held res", ed, em);
    end
    start = 1'b0;
    @(negedge clk);
    check_ctl("held end", 1'b0, 1'b0);

    // Reset at edge k+3 aborts the conversion and clears the previous results.
    start = 1'b1; rd_bcd = 8'h47; sel_hora = 1'b0; sf_24_12 = 1'b0;
    @(negedge clk);
    start = 1'b0;
    repeat (2) @(negedge clk);
    reset = 1'b1;
    @(negedge clk);
    reset = 1'b0;
    ed = '0;
    check_ctl("abort", 1'b0, 1'b0);
    check_res("abort", ed, ed);
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      check_ctl("abort idle", 1'b0, 1'b0);
    end
    convert("post_rst", 8'h23, 1'b0, 1'b0, 1'b0);

    for (int n = 0; n < 40; n++) begin
      b = 8'($urandom);
      if ($urandom_range(0, 3) != 0)
        b = {1'($urandom), 7'd0} | {4'($urandom_range(0, 9)), 4'($urandom_range(0, 9))};
      convert("rand", b, 1'($urandom), 1'($urandom), 1'($urandom_range(0, 4) == 0));
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
